// File: rtl/stopwatch_controls_pkg.sv
// rtl/stopwatch_controls_pkg.sv - stopwatch state codes, defaults and transition rule
package stopwatch_controls_pkg;

  typedef enum logic [1:0] {
    ST_ZERO    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_ILLEGAL = 2'd3
  } sw_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef struct packed {
    sw_state_e state;
    logic      clear;
  } sw_step_t;

  // Clear beats start only in PAUSE; in ZERO and RUN a simultaneous start wins.
  function automatic sw_step_t sw_next(input sw_state_e cur, input logic start, input logic clear);
    sw_step_t s;
    s.state = cur;
    s.clear = 1'b0;
    case (cur)
      ST_ZERO: begin
        if (start)      s.state = ST_RUN;
        else if (clear) s.clear = 1'b1;
      end
      ST_RUN: begin
        if (start) s.state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear) begin
          s.state = ST_ZERO;
          s.clear = 1'b1;
        end else if (start) begin
          s.state = ST_RUN;
        end
      end
      default: s.state = ST_ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_controls_button_debouncer.sv
// rtl/stopwatch_controls_button_debouncer.sv - button synchroniser, debouncer and press strobe
module button_debouncer
  import stopwatch_controls_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], raw};
      r_press <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Strobe is registered with the level flip so it lands one clk ahead of the FSM.
        r_level <= w_sync;
        r_cnt   <= '0;
        r_press <= w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/stopwatch_controls.sv
// rtl/stopwatch_controls.sv - stopwatch run/pause/clear control front end
module stopwatch_controls
  import stopwatch_controls_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start_raw,
  input  logic       btn_clear_raw,
  output logic       hold_count,
  output logic       clear_pulse,
  output logic       running,
  output logic [1:0] state
);

  logic      w_start_press;
  logic      w_clear_press;
  sw_step_t  w_step;
  sw_state_e r_state;
  logic      r_hold;
  logic      r_clear;
  logic      r_running;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk(clk), .reset_n(reset_n), .raw(btn_start_raw), .level(), .press(w_start_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk(clk), .reset_n(reset_n), .raw(btn_clear_raw), .level(), .press(w_clear_press)
  );

  assign w_step = sw_next(r_state, w_start_press, w_clear_press);

  // Outputs are decoded from the next state so they change together with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_ZERO;
      r_hold    <= 1'b1;
      r_clear   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_step.state;
      r_hold    <= (w_step.state != ST_RUN);
      r_running <= (w_step.state == ST_RUN);
      r_clear   <= w_step.clear;
    end
  end

  assign hold_count  = r_hold;
  assign clear_pulse = r_clear;
  assign running     = r_running;
  assign state       = r_state;

endmodule

// File: tb/tb_stopwatch_controls.sv
// tb/tb_stopwatch_controls.sv - scoreboard bench for stopwatch_controls
module tb_stopwatch_controls;

  localparam int DC = 4;
  localparam int SS = 2;
  localparam int HL = SS + DC;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       b_start = 1'b0;
  logic       b_clear = 1'b0;
  logic       hold_count;
  logic       clear_pulse;
  logic       running;
  logic [1:0] state;

  stopwatch_controls #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .btn_start_raw(b_start), .btn_clear_raw(b_clear),
    .hold_count(hold_count), .clear_pulse(clear_pulse), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int st;
    int pulse;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: a button level flips once the raw input, seen SS clocks late,
  // has held the opposite value for DC consecutive samples; the FSM acts one clk later.
  int m_cyc = 0;
  int m_state = 0;
  int m_nxt;
  int m_pulse;
  bit m_diff;
  bit m_level[2];
  bit m_pend[2];
  bit hist[2][HL];
  exp_t m_e;

  task automatic model_reset();
    m_state = 0;
    for (int b = 0; b < 2; b++) begin
      m_level[b] = 1'b0;
      m_pend[b]  = 1'b0;
      for (int k = 0; k < HL; k++) hist[b][k] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    m_cyc++;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_nxt = m_state;
      m_pulse = 0;
      if (m_state == 0) begin
        if (m_pend[0]) m_nxt = 1;
        else if (m_pend[1]) m_pulse = 1;
      end else if (m_state == 1) begin
        if (m_pend[0]) m_nxt = 2;
      end else begin
        if (m_pend[1]) begin
          m_nxt = 0;
          m_pulse = 1;
        end else if (m_pend[0]) begin
          m_nxt = 1;
        end
      end
      if (m_nxt != m_state || m_pulse != 0) begin
        m_e.cyc = m_cyc;
        m_e.st = m_nxt;
        m_e.pulse = m_pulse;
        exp_q.push_back(m_e);
      end
      m_state = m_nxt;
      for (int b = 0; b < 2; b++) begin
        for (int k = HL - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = (b == 0) ? b_start : b_clear;
        m_diff = 1'b1;
        for (int k = SS; k < HL; k++) if (hist[b][k] == m_level[b]) m_diff = 1'b0;
        m_pend[b] = 1'b0;
        if (m_diff) begin
          m_level[b] = ~m_level[b];
          m_pend[b] = m_level[b];
        end
      end
    end
  end

  // Monitor: every state change or clear pulse is an output event matched against the queue.
  int   mon_cyc = 0;
  int   prev_st = 0;
  exp_t got;

  always @(posedge clk) begin
    mon_cyc++;
    #1;
    if (!reset_n) begin
      prev_st = 0;
    end else if (int'(state) != prev_st || clear_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event cyc=%0d actual state=%0d clear_pulse=%0d required no event",
                 mon_cyc, state, clear_pulse);
      end else begin
        got = exp_q.pop_front();
        check("event_cycle", mon_cyc, got.cyc);
        check("event_state", int'(state), got.st);
        check("event_clear_pulse", int'(clear_pulse), got.pulse);
        check("event_hold_count", int'(hold_count), (got.st == 1) ? 0 : 1);
        check("event_running", int'(running), (got.st == 1) ? 1 : 0);
      end
      prev_st = int'(state);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit c);
    @(negedge clk);
    b_start = s;
    b_clear = c;
    step(8);
    b_start = 1'b0;
    b_clear = 1'b0;
    step(10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold_count"}, int'(hold_count), 1);
    check({tag, "_clear_pulse"}, int'(clear_pulse), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_state"}, int'(state), 0);
  endtask

  int ds = 0;
  int dcl = 0;

  initial begin
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(2);

    // Bouncy start press: 1,0,1,0 then held high.
    b_start = 1'b1; @(negedge clk);
    b_start = 1'b0; @(negedge clk);
    b_start = 1'b1; @(negedge clk);
    b_start = 1'b0; @(negedge clk);
    b_start = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("bounce_state_before", int'(state), 0);
    @(posedge clk);
    #1 check("bounce_state_at7", int'(state), 1);
    check("bounce_hold_at7", int'(hold_count), 0);
    step(10);
    b_start = 1'b0;
    step(12);

    // Glitch shorter than the debounce window.
    b_start = 1'b1;
    step(3);
    b_start = 1'b0;
    step(12);
    check("glitch_counter", int'(dut.u_start.r_cnt), 0);
    check("glitch_state", int'(state), 1);

    // Clear ignored while running, then start, clear.
    press(1'b0, 1'b1);
    check("clear_in_run_state", int'(state), 1);
    press(1'b1, 1'b0);
    check("pause_state", int'(state), 2);
    press(1'b0, 1'b1);
    check("cleared_state", int'(state), 0);

    // Simultaneous presses in PAUSE and in ZERO.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("simul_pause_state", int'(state), 0);
    press(1'b1, 1'b1);
    check("simul_zero_state", int'(state), 1);

    // Reset while a start press is still debouncing.
    b_start = 1'b1;
    step(3);
    #2 reset_n = 1'b0;
    b_start = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    step(15);
    check("after_reset_state", int'(state), 0);
    check("after_reset_hold", int'(hold_count), 1);
    press(1'b1, 1'b0);
    check("new_press_state", int'(state), 1);

    // Random bouncy activity on both buttons.
    for (int i = 0; i < 800; i++) begin
      if (ds == 0) begin
        b_start = ~b_start;
        ds = $urandom_range(1, 7);
      end
      if (dcl == 0) begin
        b_clear = ~b_clear;
        dcl = $urandom_range(1, 7);
      end
      ds--;
      dcl--;
      @(negedge clk);
    end
    b_start = 1'b0;
    b_clear = 1'b0;
    step(20);
    check("queue_drained", exp_q.size(), 0);
    check("final_state", int'(state), m_state);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
